// File: rtl/led_write_sched.sv
// LED write scheduler: 2-entry request FIFO feeding one-cycle LED register writes,
// with optional blink overlay enabled by defining LED_BLINK_EN.
module led_write_sched #(
  parameter logic [23:0] BLINK_PERIOD = 24'd12_500_000
) (
  input  logic        led_clk,
  input  logic        ledrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        ledcs,
  output logic [1:0]  ledaddr,
  output logic [15:0] ledwdata,
  output logic        busy,
  output logic        blink_on
);

  typedef enum logic [1:0] {IDLE, CPU_WR, BLINK_WR} state_t;

  logic [17:0] r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_blink_go;
  logic [1:0]  w_head_addr;
  logic [15:0] w_head_data;
  logic        w_blink_pending;
  logic [15:0] w_blink_data;
  logic        r_ledcs;
  logic [1:0]  r_ledaddr;
  logic [15:0] r_ledwdata;
  logic [15:0] r_shadow;

  function automatic logic [15:0] f_merge(input logic [15:0] cur, input logic [1:0] a,
                                          input logic [15:0] d);
    case (a)
      2'b01:   f_merge = {cur[15:8], d[7:0]};
      2'b10:   f_merge = {d[7:0], cur[7:0]};
      default: f_merge = d;
    endcase
  endfunction

  assign req_ready   = !ledrst && (r_count != 2'd2);
  assign w_push      = req_valid && req_ready;
  assign w_head_addr = r_mem[r_rptr][17:16];
  assign w_head_data = r_mem[r_rptr][15:0];

  always_ff @(posedge led_clk) begin
    if (w_push) r_mem[r_wptr] <= {req_addr, req_wdata};
    if (ledrst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Every write occupies two cycles: the strobe slot and a mandatory return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_blink_go  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != 2'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = CPU_WR;
        end else if (w_blink_pending) begin
          w_blink_go  = 1'b1;
          w_state_nxt = BLINK_WR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge led_clk) begin
    if (ledrst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_ledcs    <= 1'b0;
      r_ledaddr  <= 2'b00;
      r_ledwdata <= 16'h0000;
      r_shadow   <= 16'h0000;
    end else begin
      r_ledcs <= 1'b0;
      if (w_pop && (w_head_addr != 2'b00)) begin
        r_ledcs    <= 1'b1;
        r_ledaddr  <= w_head_addr;
        r_ledwdata <= w_head_data;
        r_shadow   <= f_merge(r_shadow, w_head_addr, w_head_data);
      end else if (w_blink_go) begin
        r_ledcs    <= 1'b1;
        r_ledaddr  <= 2'b11;
        r_ledwdata <= w_blink_data;
      end
    end
  end

`ifdef LED_BLINK_EN
  logic [15:0] r_blink_mask;
  logic [23:0] r_blink_cnt;
  logic        r_phase;
  logic        r_blink_pending;
  logic        w_mask_wr;
  logic        w_wrap;

  assign w_mask_wr       = w_pop && (w_head_addr == 2'b00);
  assign w_wrap          = (r_blink_mask != 16'h0000) && (r_blink_cnt == BLINK_PERIOD - 24'd1);
  assign w_blink_pending = r_blink_pending;
  assign w_blink_data    = r_phase ? r_shadow : (r_shadow & ~r_blink_mask);
  assign blink_on        = (r_blink_mask != 16'h0000);

  // Clearing the mask mid-"off" phase queues exactly one restore write.
  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_blink_mask    <= 16'h0000;
      r_blink_cnt     <= 24'd0;
      r_phase         <= 1'b0;
      r_blink_pending <= 1'b0;
    end else begin
      if (w_blink_go) r_phase <= ~r_phase;
      if (w_mask_wr) r_blink_mask <= w_head_data;
      if (w_mask_wr && (w_head_data == 16'h0000)) begin
        r_blink_cnt     <= 24'd0;
        r_blink_pending <= r_phase;
      end else begin
        if (r_blink_mask != 16'h0000)
          r_blink_cnt <= w_wrap ? 24'd0 : r_blink_cnt + 24'd1;
        if (w_blink_go)  r_blink_pending <= 1'b0;
        else if (w_wrap) r_blink_pending <= 1'b1;
      end
    end
  end
`else
  assign w_blink_pending = 1'b0;
  assign w_blink_data    = r_shadow;
  assign blink_on        = 1'b0;
`endif

  assign ledcs    = r_ledcs;
  assign ledaddr  = r_ledaddr;
  assign ledwdata = r_ledwdata;
  assign busy     = (r_count != 2'd0) || w_blink_pending || (r_state != IDLE);

endmodule
